// File: rtl/spi_clear_pkg.sv
// spi_clear shared definitions: panel command bytes, sequencer states
// and header-index helpers.
package spi_clear_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [3:0] HDR_PIX = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND,
        FINISH
    } state_t;

    function automatic logic hdr_is_cmd(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10);
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// 8-bit MSB-first load/shift serializer; last flags the final bit so the
// next byte can be loaded on the same edge with no gap cycle.
module spi_byte_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clr,
    input  logic [7:0] data,
    output logic       bit_out,
    output logic       last
);

    logic [7:0] sh;
    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= data;
            cnt <= '0;
        end else if (clr) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh  <= {sh[6:0], 1'b0};
            cnt <= cnt + 3'd1;
        end
    end

    assign bit_out = sh[7];
    assign last    = (cnt == 3'd7);

endmodule

// File: rtl/spi_clear.sv
// ILI9341 full-screen clear sequencer: CASET/PASET window, RAMWR, fill.
// Define SPI_CLEAR_COLOR_EN to fill with COLOR instead of black.
module spi_clear
    import spi_clear_pkg::*;
#(
    parameter int          DELAY  = 20,
    parameter int          WIDTH  = 240,
    parameter int          HEIGHT = 320,
    parameter logic [15:0] COLOR  = 16'h0000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_mosi,
    output logic o_dc,
    output logic o_cs,
    output logic o_done
);

    localparam longint unsigned NPIX = longint'(WIDTH) * longint'(HEIGHT);
    localparam int PW = $clog2(NPIX + 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX);
    localparam int DW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [DW-1:0] DLY_INIT = DW'(DELAY);
    localparam logic [15:0] W_END = 16'(WIDTH - 1);
    localparam logic [15:0] H_END = 16'(HEIGHT - 1);

`ifdef SPI_CLEAR_COLOR_EN
    localparam logic [15:0] PIX_FILL = COLOR;
`else
    localparam logic [15:0] PIX_FILL = COLOR & 16'h0000;
`endif

    state_t          state;
    logic [DW-1:0]   dly;
    logic [3:0]      idx;
    logic            half;
    logic [PW-1:0]   pix;

    logic [7:0]      nxt_byte;
    logic            nxt_dc;
    logic            seq_end;
    logic            tx_load;
    logic            tx_clr;
    logic            tx_last;

    always_comb begin
        nxt_byte = 8'h00;
        nxt_dc   = 1'b1;
        if (idx == HDR_PIX) begin
            nxt_byte = half ? PIX_FILL[7:0] : PIX_FILL[15:8];
        end else begin
            nxt_dc = ~hdr_is_cmd(idx);
            unique case (idx)
                4'd0:    nxt_byte = CMD_CASET;
                4'd3:    nxt_byte = W_END[15:8];
                4'd4:    nxt_byte = W_END[7:0];
                4'd5:    nxt_byte = CMD_PASET;
                4'd8:    nxt_byte = H_END[15:8];
                4'd9:    nxt_byte = H_END[7:0];
                4'd10:   nxt_byte = CMD_RAMWR;
                default: nxt_byte = 8'h00;
            endcase
        end
    end

    // Stream is over once every pixel's low byte has been loaded
    assign seq_end = (idx == HDR_PIX) && !half && (pix == PIX_LAST);
    assign tx_load = ((state == WAIT) && (dly == '0))
                   || ((state == SEND) && tx_last && !seq_end);
    assign tx_clr  = (state != SEND);

    spi_byte_tx u_tx (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .load    (tx_load),
        .clr     (tx_clr),
        .data    (nxt_byte),
        .bit_out (o_mosi),
        .last    (tx_last)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            dly    <= '0;
            idx    <= '0;
            half   <= 1'b0;
            pix    <= '0;
            o_cs   <= 1'b1;
            o_dc   <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (tx_load) begin
                o_dc <= nxt_dc;
                if (idx != HDR_PIX) begin
                    idx <= idx + 4'd1;
                end else begin
                    half <= ~half;
                    if (half)
                        pix <= pix + PW'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    o_cs <= 1'b1;
                    o_dc <= 1'b0;
                    if (i_start) begin
                        state <= WAIT;
                        dly   <= DLY_INIT;
                        idx   <= '0;
                        half  <= 1'b0;
                        pix   <= '0;
                    end
                end
                WAIT: begin
                    if (dly == '0) begin
                        state <= SEND;
                        o_cs  <= 1'b0;
                    end else begin
                        dly <= dly - DW'(1);
                    end
                end
                SEND: begin
                    if (tx_last && seq_end) begin
                        state  <= FINISH;
                        o_cs   <= 1'b1;
                        o_dc   <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_clear.sv
// Directed bench for spi_clear: reset, full frames, busy start, abort,
// and a small second instance for the fill-colour path.
module tb_spi_clear;

    localparam int D1 = 20;
    localparam int W1 = 24;
    localparam int H1 = 32;
    localparam int D2 = 3;
    localparam int W2 = 2;
    localparam int H2 = 2;

`ifdef SPI_CLEAR_COLOR_EN
    localparam logic [15:0] P1 = 16'h1234;
    localparam logic [15:0] P2 = 16'hF800;
`else
    localparam logic [15:0] P1 = 16'h0000;
    localparam logic [15:0] P2 = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start2;
    logic mosi1, dc1, cs1, done1;
    logic mosi2, dc2, cs2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    bit q_bits[$];
    bit q_dc[$];
    int cs_fall;
    int done_k;
    int done_n;
    logic cs_at_done;

    always #5 clk = ~clk;

    spi_clear #(.DELAY(D1), .WIDTH(W1), .HEIGHT(H1), .COLOR(16'h1234)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_start (start1),
        .o_mosi  (mosi1),
        .o_dc    (dc1),
        .o_cs    (cs1),
        .o_done  (done1)
    );

    spi_clear #(.DELAY(D2), .WIDTH(W2), .HEIGHT(H2), .COLOR(16'hF800)) u_dut2 (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_start (start2),
        .o_mosi  (mosi2),
        .o_dc    (dc2),
        .o_cs    (cs2),
        .o_done  (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int sel, input int maxc, input int poke_at);
        logic cs, mo, dc, dn;
        q_bits.delete();
        q_dc.delete();
        cs_fall = -1;
        done_k = -1;
        done_n = 0;
        cs_at_done = 1'bx;
        @(negedge clk);
        if (sel == 0) start1 = 1'b1;
        else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clk);
            @(negedge clk);
            cs = sel ? cs2 : cs1;
            mo = sel ? mosi2 : mosi1;
            dc = sel ? dc2 : dc1;
            dn = sel ? done2 : done1;
            if (k == poke_at) begin
                if (sel == 0) start1 = 1'b1;
                else start2 = 1'b1;
            end
            if (k == poke_at + 1) begin
                start1 = 1'b0;
                start2 = 1'b0;
            end
            if (cs === 1'b0) begin
                if (cs_fall < 0) cs_fall = k;
                q_bits.push_back(mo);
                q_dc.push_back(dc);
            end
            if (dn === 1'b1) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    cs_at_done = cs;
                end
            end
            if (done_k >= 0 && k >= done_k + 3) break;
        end
    endtask

    task automatic check_frame(input string nm, input int d, input int w,
                               input int h, input logic [15:0] p);
        logic [7:0] hdr [11];
        logic [15:0] we, he;
        logic [7:0] b;
        int nbits, nbytes, bad_pix, bad_dc;
        bit exp_dc;
        nbits = 88 + 16 * w * h;
        we = 16'(w - 1);
        he = 16'(h - 1);
        hdr = '{8'h2A, 8'h00, 8'h00, we[15:8], we[7:0],
                8'h2B, 8'h00, 8'h00, he[15:8], he[7:0], 8'h2C};
        check({nm, "_cs_fall"}, cs_fall, d + 1);
        check({nm, "_done_at"}, done_k, d + nbits + 1);
        check({nm, "_done_cnt"}, done_n, 1);
        check({nm, "_cs_at_done"}, {31'd0, cs_at_done}, 1);
        check({nm, "_nbits"}, q_bits.size(), nbits);
        nbytes = q_bits.size() / 8;
        bad_pix = 0;
        bad_dc = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = '0;
            exp_dc = !(i == 0 || i == 5 || i == 10);
            for (int j = 0; j < 8; j++) begin
                b = {b[6:0], q_bits[8 * i + j]};
                if (q_dc[8 * i + j] != exp_dc) bad_dc++;
            end
            if (i < 11) begin
                check($sformatf("%s_hdr%0d", nm, i), b, hdr[i]);
            end else if (b != (((i - 11) % 2 == 0) ? p[15:8] : p[7:0])) begin
                bad_pix++;
            end
        end
        check({nm, "_pix_bad"}, bad_pix, 0);
        check({nm, "_dc_bad"}, bad_dc, 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs1, 1);
        check("rst_mosi", mosi1, 0);
        check("rst_dc", dc1, 0);
        check("rst_done", done1, 0);
        check("rst_cs2", cs2, 1);

        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({cs1, mosi1, dc1, done1, cs2, done2} !== 6'b100010) bad++;
        end
        check("idle_stable", bad, 0);

        capture(0, 13000, -1);
        check_frame("f1", D1, W1, H1, P1);

        capture(0, 13000, 300);
        check_frame("busy", D1, W1, H1, P1);

        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("pre_abort_cs", cs1, 0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", cs1, 1);
        check("abort_mosi", mosi1, 0);
        check("abort_done", done1, 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done1 !== 1'b0 || cs1 !== 1'b1) bad++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done1 !== 1'b0 || cs1 !== 1'b1) bad++;
        end
        check("abort_quiet", bad, 0);

        capture(0, 13000, -1);
        check_frame("post", D1, W1, H1, P1);

        capture(1, 400, -1);
        check_frame("small", D2, W2, H2, P2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_clear.md
# spi_clear

Display-clear sequencer for an ILI9341-class SPI TFT panel. On a start pulse it drives one chip-select-framed transaction: set the column and page windows to the full WIDTH×HEIGHT area, issue Memory Write, then stream one fill pixel per screen location. It sits between the display top-level controller, which owns start sequencing, and the panel pins. SCK is the system clock routed inverted to the panel outside this block.

## Interface
- DELAY, 20: idle cycles between accepted start and first transmitted bit (CS setup).
- WIDTH, 240: panel width in pixels, 1..65536.
- HEIGHT, 320: panel height in pixels, 1..65536.
- COLOR, 16'h0000: RGB565 fill value; effective only with SPI_CLEAR_COLOR_EN.
- i_clk  in  1  system clock; also the SPI bit clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  start request, sampled on rising i_clk.
- o_mosi  out  1  serial data, MSB first.
- o_dc  out  1  data/command select: 0 = command byte, 1 = parameter/pixel byte.
- o_cs  out  1  panel chip select, active-low.
- o_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → WAIT → SEND → FINISH → IDLE.
- IDLE: o_cs=1, o_mosi=0, o_dc=0. i_start=1 moves to WAIT and loads the delay counter.
- WAIT: counts DELAY cycles, then enters SEND. DELAY=0 enters SEND directly.
- SEND: o_cs=0. Bytes go back to back, 8 cycles each, MSB first, with no gaps. Byte order:
  - 0x2A (dc=0), then 0x00, 0x00, (WIDTH-1)[15:8], (WIDTH-1)[7:0] (dc=1).
  - 0x2B (dc=0), then 0x00, 0x00, (HEIGHT-1)[15:8], (HEIGHT-1)[7:0] (dc=1).
  - 0x2C (dc=0).
  - WIDTH*HEIGHT pixels, each as high byte then low byte of the fill value (dc=1).
- FINISH: o_cs=1, o_done=1 for exactly one cycle, then IDLE.
- i_start is ignored outside IDLE. It is level-sampled: if it is held high it is seen again in the IDLE cycle that follows FINISH.
- Pixel counter width is $clog2(WIDTH*HEIGHT+1). Window end values are truncated to 16 bits.

## Timing
- Reset (i_rst=0, asynchronous) forces o_cs=1, o_mosi=0, o_dc=0, o_done=0, state IDLE, and clears all counters.
- Reset mid-transaction aborts immediately. No o_done is produced, and CS rises asynchronously.
- All outputs are registered and change only on the rising edge of i_clk. The panel samples on the rising edge of the inverted clock, i.e. mid-bit.
- Let T0 be the edge that samples i_start=1:
  - o_cs falls and the first bit (MSB of 0x2A) appears at edge T0+DELAY+1.
  - N = 88 + 16·WIDTH·HEIGHT bits follow, one per cycle.
  - o_dc changes only at byte boundaries, together with the byte's MSB.
  - At edge T0+DELAY+N+1, o_cs rises and o_done is asserted for one cycle.
- The earliest next accepted start is the edge after o_done.

## Configuration
- SPI_CLEAR_COLOR_EN defined: pixel bytes are COLOR[15:8], COLOR[7:0].
- Undefined: pixel bytes are 0x00, 0x00 (black). The COLOR parameter is accepted but unused.

## Structure
- Package spi_clear_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C;
  - the state enum (IDLE, WAIT, SEND, FINISH).
- Sub-module spi_byte_tx: an 8-bit load/shift serializer with byte-done strobe, MSB first, one bit per cycle, able to reload without a gap cycle.
- The top level holds the state machine, the byte sequencer (index 0..10 for header bytes) and the pixel/byte-half counter.

## Test plan
- Reset: hold i_rst=0 → o_cs=1, o_mosi=0, o_dc=0, o_done=0. Release with i_start=0 → outputs unchanged for 100 cycles.
- Full clear with DELAY=20, WIDTH=24, HEIGHT=32, one-cycle i_start:
  - o_cs falls 21 cycles after the start sample;
  - header bytes decoded as 2A 00 00 00 17 2B 00 00 00 1F 2C;
  - 1536 data bytes all 0x00;
  - o_cs rises and o_done pulses exactly 12376+21 cycles after the start sample.
- DC framing: o_dc=0 exactly during the 0x2A, 0x2B and 0x2C bytes, and 1 for every other byte while o_cs=0.
- Busy start: pulse i_start mid-stream → byte stream and o_done timing identical to the undisturbed run; exactly one o_done.
- Abort: assert i_rst=0 during pixel streaming → o_cs=1 immediately, no o_done. A new start afterwards produces a complete correct frame.
- Color option: with SPI_CLEAR_COLOR_EN and COLOR=16'hF800, WIDTH=2, HEIGHT=2 → pixel bytes F8 00 repeated 4 times, o_done at cycle 88+64+DELAY+1.
